// File: rtl/conv3x3_engine.sv
// 3x3 signed-kernel convolution sequencer: reads a source image RAM, writes a
// packed "valid" output image of clamped 8-bit pixels into a destination RAM.
module conv3x3_engine #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [71:0]       kernel,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

  localparam int ACC_W = 22;
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OW_A   = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(IMG_H - 3);
  localparam logic signed [ACC_W-1:0] PIX_MAX = 255;

  state_t state, state_nx;

  logic signed [7:0]       taps [9];
  logic [ADDR_W-1:0]       r, c;
  logic [3:0]              k;
  logic signed [ACC_W-1:0] acc;
  logic [1:0]              ti, tj;
  logic [3:0]              tap_idx;
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              pix;
  logic                    last_pix;

  // k runs 0..8 during READ and sits at 9 in LAST, so tap k-1 always pairs
  // with the pixel read one cycle earlier.
  always_comb begin
    if (k >= 4'd6) begin
      ti = 2'd2;
      tj = 2'(k - 4'd6);
    end else if (k >= 4'd3) begin
      ti = 2'd1;
      tj = 2'(k - 4'd3);
    end else begin
      ti = 2'd0;
      tj = 2'(k);
    end
    tap_idx = (k == 4'd0) ? 4'd0 : k - 4'd1;
    prod    = $signed({1'b0, rd_data}) * taps[tap_idx];
    shifted = acc >>> SHIFT;
    if (shifted[ACC_W-1])
      pix = '0;
    else if (shifted > PIX_MAX)
      pix = '1;
    else
      pix = shifted[7:0];
    last_pix = (r == R_LAST) && (c == C_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = READ;
      READ: begin
        rd_en = 1'b1;
        if (k == 4'd8) state_nx = LAST;
      end
      LAST:  state_nx = WRITE;
      WRITE: begin
        wr_en    = 1'b1;
        state_nx = last_pix ? DONE : READ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    if (rd_en) rd_addr = (r + ADDR_W'(ti)) * W_A + c + ADDR_W'(tj);
    if (wr_en) begin
      wr_addr = r * OW_A + c;
      wr_data = pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      r   <= '0;
      c   <= '0;
      k   <= '0;
      for (int unsigned i = 0; i < 9; i++) taps[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          for (int unsigned i = 0; i < 9; i++) taps[i] <= kernel[8*i +: 8];
          acc <= '0;
          r   <= '0;
          c   <= '0;
          k   <= '0;
        end
        READ: begin
          if (k != 4'd0) acc <= acc + ACC_W'(prod);
          k <= k + 4'd1;
        end
        LAST: acc <= acc + ACC_W'(prod);
        WRITE: begin
          acc <= '0;
          k   <= '0;
          if (c == C_LAST) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine on a reduced, non-square image with
// RAM models and a direct-sum convolution reference.
module tb_conv3x3_engine;
  localparam int W  = 16;
  localparam int H  = 12;
  localparam int AW = 12;
  localparam int SH = 4;
  localparam int OW = W - 2;
  localparam int OH = H - 2;
  localparam int N  = OW * OH;
  localparam int RUN_CYC = 11 * N;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [71:0]   kernel;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data = '0;
  logic [7:0]    wr_data;

  conv3x3_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel(kernel),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [7:0] src [W*H];
  int dst  [N];
  int expv [N];

  always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

  int total = 0, bad = 0;
  int cnt, overlap, idle_nz, wr_cnt, done_cnt, done_at, first_rd, first_wr, busy_low_at;
  logic [AW-1:0] rd_seq [$];

  always @(negedge clk) begin
    cnt++;
    if (rd_en && wr_en) overlap++;
    if ((!rd_en && rd_addr != 0) || (!wr_en && (wr_addr != 0 || wr_data != 0))) idle_nz++;
    if (rd_en) begin
      if (first_rd == 0) first_rd = cnt;
      if (rd_seq.size() < 9) rd_seq.push_back(rd_addr);
    end
    if (wr_en) begin
      if (first_wr == 0) first_wr = cnt;
      if (int'(wr_addr) < N) dst[wr_addr] = int'(wr_data);
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (done_at == 0) done_at = cnt;
    end
    if (!busy && busy_low_at == 0) busy_low_at = cnt;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  typedef struct {
    logic [71:0] kern;
    int          mode;  // 0 ramp a%256, 1 constant val, 2 random
    int          val;
    int          expc;  // -1: use reference model, else every pixel equals this
  } vec_t;

  vec_t vecs [7];

  function automatic logic [71:0] kfill(input int center, input int other);
    logic [71:0] kv;
    for (int t = 0; t < 9; t++) kv[8*t +: 8] = 8'((t == 4) ? center : other);
    return kv;
  endfunction

  function automatic void model(input logic [71:0] kv);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        int s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(src[(r+i)*W + c + j]) * int'($signed(kv[8*(3*i+j) +: 8]));
        s = s >>> SH;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        expv[r*OW + c] = s;
      end
  endfunction

  task automatic prepare(input vec_t v);
    for (int a = 0; a < W*H; a++)
      src[a] = (v.mode == 0) ? 8'(a) : (v.mode == 1) ? 8'(v.val) : 8'($urandom);
    if (v.expc < 0) model(v.kern);
    else for (int n = 0; n < N; n++) expv[n] = v.expc;
    for (int n = 0; n < N; n++) dst[n] = -1;
  endtask

  task automatic launch(input logic [71:0] kv);
    kernel = kv;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0; overlap = 0; idle_nz = 0; wr_cnt = 0; done_cnt = 0; done_at = 0;
    first_rd = 0; first_wr = 0; busy_low_at = 0;
    rd_seq.delete();
  endtask

  task automatic run_vec(input int id, input vec_t v, input bit disturb, input bit first);
    int nbad, fn;
    prepare(v);
    launch(v.kern);
    for (int t = 1; t <= RUN_CYC + 40 && done_cnt == 0; t++) begin
      @(negedge clk);
      #1;
      if (disturb) begin
        if (t == 100) begin
          start  = 1'b1;
          kernel = ~v.kern;
        end
        if (t == 105) start = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    check($sformatf("v%0d_done_cnt", id), done_cnt, 1);
    check($sformatf("v%0d_done_cycle", id), done_at, RUN_CYC + 1);
    check($sformatf("v%0d_busy_low_cycle", id), busy_low_at, RUN_CYC + 2);
    check($sformatf("v%0d_writes", id), wr_cnt, N);
    check($sformatf("v%0d_rd_wr_overlap", id), overlap, 0);
    check($sformatf("v%0d_idle_outputs_nonzero", id), idle_nz, 0);
    nbad = 0;
    fn = -1;
    for (int n = 0; n < N; n++)
      if (dst[n] != expv[n]) begin
        if (fn < 0) fn = n;
        nbad++;
      end
    check($sformatf("v%0d_bad_pixels", id), nbad, 0);
    if (fn >= 0) $display("  first differing pixel %0d: got %0d expected %0d", fn, dst[fn], expv[fn]);
    if (first) begin
      check("first_rd_cycle", first_rd, 1);
      check("first_wr_cycle", first_wr, 11);
      check("rd_seq_len", rd_seq.size(), 9);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          check($sformatf("rd_seq_%0d", 3*i+j), int'(rd_seq[3*i+j]), i*W + j);
      check("ident_px0", dst[0], W + 1);
      check("ident_px1", dst[1], W + 2);
      check("ident_row1", dst[OW], 2*W + 1);
    end
  endtask

  initial begin
    vec_t rv;
    int w0;
    rst = 1'b1;
    start = 1'b0;
    kernel = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl_outs", int'({busy, done, rd_en, wr_en}), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_bus", int'({wr_addr, wr_data}), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    vecs[0] = '{kfill(16, 0),    0, 0,   -1};
    vecs[1] = '{kfill(1, 1),     1, 200, 112};
    vecs[2] = '{kfill(-16, 0),   1, 100, 0};
    vecs[3] = '{kfill(127, 127), 1, 255, 255};
    vecs[4] = '{kfill(8, -1),    1, 77,  0};
    vecs[5] = '{72'({$urandom, $urandom, $urandom}), 2, 0, -1};
    vecs[6] = '{72'({$urandom, $urandom, $urandom}), 2, 0, -1};

    for (int v = 0; v < 7; v++) run_vec(v, vecs[v], v == 6, v == 0);

    // Abort mid-run with reset, then confirm a clean rerun.
    rv = '{72'({$urandom, $urandom, $urandom}), 2, 0, -1};
    prepare(rv);
    launch(rv.kern);
    for (int t = 1; t < 500; t++) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_ctrl_outs", int'({busy, done, rd_en, wr_en}), 0);
    rst = 1'b0;
    check("abort_writes_before", wr_cnt, 500 / 11);
    w0 = wr_cnt;
    repeat (30) @(negedge clk);
    #1;
    check("abort_no_more_writes", wr_cnt, w0);
    check("abort_idle_busy", int'(busy), 0);
    run_vec(7, rv, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
